seq_fir: RTL and testbench

Parametrised, single-multiplier FIR filter that succeeds the fixed 5-tap non-pipelined FIR. Width, tap count, output width and scaling are generic, and coefficients are run-time loadable. Each accepted sample is stored in a circular sample buffer and convolved with TAPS coefficients, one MAC per cycle. The result is then presented on a valid/ready output. The block sits between the sample source (BRAM reader) and the result sink (BRAM writer) of the FIR comparison project.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_mac.sv | 30 +++
 rtl/seq_fir.sv | 89 ++++++++
 tb/tb_seq_fir.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared state type and arithmetic helpers for the seq_fir filter.
// Contents: state_t (IDLE/MAC/OUT), acc_width() for the accumulator width,
// fit_out() reducing a widened accumulator value to the output width.
// Build option: FIR_SAT_EN selects saturation in fit_out(); otherwise wrap-around.
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   function automatic int acc_width(input int dw, input int cw, input int taps);
      return dw + cw + $clog2(taps);
   endfunction

   // Result is sign-extended from ow bits so the caller may simply keep the low ow bits.
   function automatic logic signed [63:0] fit_out(input logic signed [63:0] v, input int ow);
`ifdef FIR_SAT_EN
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (v > hi) ? hi : (v < lo) ? lo : v;
`else
      return (v <<< (64 - ow)) >>> (64 - ow);
`endif
   endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate unit used once per tap by seq_fir.
// Ports: clk, rst_n (async active-low), clr (zero acc), en (acc <= sum),
// a/b (signed operands), acc (registered accumulator), sum (acc + a*b, combinational).
module fir_mac #(
   parameter int DW = 8,
   parameter int CW = 8,
   parameter int AW = 19
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a,
   input  logic signed [CW-1:0] b,
   output logic signed [AW-1:0] acc,
   output logic signed [AW-1:0] sum
);

   logic signed [DW+CW-1:0] prod;

   assign prod = a * b;
   // Signed size cast sign-extends the product to the accumulator width.
   assign sum  = acc + AW'(prod);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= sum;

endmodule

// File: rtl/seq_fir.sv
// seq_fir: single-multiplier sequential FIR with run-time loadable coefficients.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/data_in (sample input);
// coef_we/coef_addr/coef_data (coefficient write, only while idle);
// out_valid/out_ready/data_out (filtered result); busy (MAC or OUT state).
// Build option: FIR_SAT_EN saturates data_out instead of wrapping.
module seq_fir
   import fir_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int COEF_WIDTH = 8,
   parameter int TAPS       = 5,
   parameter int OUT_WIDTH  = 16,
   parameter int SHIFT      = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   input  logic                         coef_we,
   input  logic [$clog2(TAPS)-1:0]      coef_addr,
   input  logic signed [COEF_WIDTH-1:0] coef_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [OUT_WIDTH-1:0]  data_out,
   output logic                         busy
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);
   localparam int IW        = $clog2(TAPS);

   state_t state, state_nxt;
   logic [IW-1:0] wr_ptr, k, rd_idx;
   logic signed [DATA_WIDTH-1:0] sbuf [TAPS];
   logic signed [COEF_WIDTH-1:0] coef [TAPS];
   logic signed [ACC_WIDTH-1:0] acc, sum;
   logic take, last;

   assign take = state == IDLE && in_valid;
   assign last = state == MAC && k == IW'(TAPS - 1);
   // Modular arithmetic in IW bits yields the right index even when TAPS is a power of two.
   assign rd_idx = (wr_ptr >= k) ? wr_ptr - k : wr_ptr + IW'(TAPS) - k;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;

   always_comb
      state_nxt = state == IDLE ? (in_valid ? MAC : IDLE)
                : state == MAC  ? (last ? OUT : MAC)
                : out_ready     ? IDLE : OUT;

   always_comb begin
      in_ready  = state == IDLE;
      out_valid = state == OUT;
      busy      = state == MAC || state == OUT;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         k        <= '0;
         data_out <= '0;
         for (int i = 0; i < TAPS; i++) begin
            sbuf[i] <= '0;
            coef[i] <= '0;
         end
      end else begin
         if (take) sbuf[wr_ptr] <= data_in;
         k <= (state == MAC && !last) ? k + 1'b1 : '0;
         if (last) begin
            wr_ptr   <= wr_ptr == IW'(TAPS - 1) ? '0 : wr_ptr + 1'b1;
            data_out <= OUT_WIDTH'(fit_out(64'(sum >>> SHIFT), OUT_WIDTH));
         end
         if (coef_we && !busy && 32'(coef_addr) < TAPS) coef[coef_addr] <= coef_data;
      end

   fir_mac #(.DW(DATA_WIDTH), .CW(COEF_WIDTH), .AW(ACC_WIDTH)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (take),
      .en    (state == MAC),
      .a     (sbuf[rd_idx]),
      .b     (coef[k]),
      .acc   (acc),
      .sum   (sum)
   );

endmodule

// File: tb/tb_seq_fir.sv
// tb_seq_fir: directed self-checking bench for seq_fir with default parameters.
module tb_seq_fir;

   logic clk = 0, rst_n = 0, in_valid = 0, coef_we = 0, out_ready = 1;
   logic in_ready, out_valid, busy;
   logic signed [7:0] data_in = 0, coef_data = 0;
   logic [2:0] coef_addr = 0;
   logic signed [15:0] data_out;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   seq_fir dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   task automatic do_reset();
      rst_n = 0; in_valid = 0; coef_we = 0; out_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic load_coefs(input int c0, input int c1, input int c2, input int c3, input int c4);
      int c [5];
      c = '{c0, c1, c2, c3, c4};
      for (int i = 0; i < 5; i++) begin
         coef_we = 1; coef_addr = 3'(i); coef_data = 8'(c[i]);
         @(posedge clk); #1;
      end
      coef_we = 0;
   endtask

   // Presents one sample in IDLE and waits (bounded) for the result.
   task automatic send(input int x, output int y, output int lat);
      in_valid = 1; data_in = 8'(x);
      @(posedge clk); #1;
      in_valid = 0; lat = 1;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      y = out_valid ? int'(data_out) : -99999;
      if (out_valid && out_ready) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (data_out !== 16'sd0) begin errors++; $display("FAIL reset_data_out: got %0d expected 0", data_out); end
   endtask

   task automatic test_impulse();
      int exp_y [5] = '{1, 2, 3, 4, 5};
      int x [5] = '{1, 0, 0, 0, 0};
      int y, lat;
      do_reset();
      load_coefs(1, 2, 3, 4, 5);
      for (int i = 0; i < 5; i++) begin
         send(x[i], y, lat);
         checks++; if (y !== exp_y[i]) begin errors++; $display("FAIL impulse[%0d]: got %0d expected %0d", i, y, exp_y[i]); end
         checks++; if (lat !== 6) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d expected 6", i, lat); end
      end
   endtask

   task automatic test_step_wrap();
      int exp_y [6] = '{10, 20, 30, 40, 50, 50};
      int y, lat;
      time t0, t1;
      do_reset();
      load_coefs(1, 1, 1, 1, 1);
      t0 = 0; t1 = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 1) t0 = $time;
         if (i == 2) t1 = $time;
         send(10, y, lat);
         checks++; if (y !== exp_y[i]) begin errors++; $display("FAIL step[%0d]: got %0d expected %0d", i, y, exp_y[i]); end
      end
      checks++; if ((t1 - t0) !== 70) begin errors++; $display("FAIL step_period: got %0t expected 70 (7 cycles)", t1 - t0); end
   endtask

   task automatic test_backpressure();
      int y, lat;
      do_reset();
      load_coefs(1, 2, 3, 4, 5);
      out_ready = 0;
      send(1, y, lat);
      checks++; if (lat !== 6) begin errors++; $display("FAIL bp_latency: got %0d expected 6", lat); end
      checks++; if (y !== 1) begin errors++; $display("FAIL bp_first: got %0d expected 1", y); end
      in_valid = 1; data_in = 8'sd99;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== 16'sd1) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b data_out=%0d expected 1 0 1", i, out_valid, in_ready, data_out);
         end
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got in_ready=%b expected 1", in_ready); end
      send(0, y, lat);
      checks++; if (y !== 2) begin errors++; $display("FAIL bp_not_consumed: got %0d expected 2", y); end
   endtask

   task automatic test_saturation();
`ifdef FIR_SAT_EN
      int exp_y [5] = '{16384, 32767, 32767, 32767, 32767};
`else
      int exp_y [5] = '{16384, -32768, -16384, 0, 16384};
`endif
      int y, lat;
      do_reset();
      load_coefs(-128, -128, -128, -128, -128);
      for (int i = 0; i < 5; i++) begin
         send(-128, y, lat);
         checks++; if (y !== exp_y[i]) begin errors++; $display("FAIL sat[%0d]: got %0d expected %0d", i, y, exp_y[i]); end
      end
   endtask

   task automatic test_reset_mid_mac();
      int y, lat;
      do_reset();
      load_coefs(1, 2, 3, 4, 5);
      send(3, y, lat);
      checks++; if (y !== 3) begin errors++; $display("FAIL rmid_pre: got %0d expected 3", y); end
      in_valid = 1; data_in = 8'sd4;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (2) begin @(posedge clk); #1; end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
      rst_n = 0; #1;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 16'sd0) begin
         errors++;
         $display("FAIL rmid_async: got out_valid=%b busy=%b data_out=%0d expected 0 0 0", out_valid, busy, data_out);
      end
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
      send(50, y, lat);
      checks++; if (y !== 0) begin errors++; $display("FAIL rmid_zero_coef: got %0d expected 0", y); end
      load_coefs(1, 2, 3, 4, 5);
      send(0, y, lat);
      checks++; if (y !== 100) begin errors++; $display("FAIL rmid_history: got %0d expected 100", y); end
   endtask

   task automatic test_coef_busy();
      int y, lat;
      do_reset();
      load_coefs(1, 2, 3, 4, 5);
      in_valid = 1; data_in = 8'sd2;
      @(posedge clk); #1;
      in_valid = 0; coef_we = 1; coef_addr = 3'd0; coef_data = 8'sd7; lat = 1;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      coef_we = 0;
      y = int'(data_out);
      checks++; if (lat !== 6 || y !== 2) begin errors++; $display("FAIL coef_busy_cur: got %0d (lat %0d) expected 2 (lat 6)", y, lat); end
      @(posedge clk); #1;
      send(3, y, lat);
      checks++; if (y !== 7) begin errors++; $display("FAIL coef_busy_next: got %0d expected 7", y); end
   endtask

   task automatic test_same_cycle_coef();
      int y, lat;
      do_reset();
      in_valid = 1; data_in = 8'sd5; coef_we = 1; coef_addr = 3'd0; coef_data = 8'sd3;
      @(posedge clk); #1;
      in_valid = 0; coef_we = 0; lat = 1;
      while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      y = int'(data_out);
      checks++; if (lat !== 6 || y !== 15) begin errors++; $display("FAIL same_cycle_coef: got %0d (lat %0d) expected 15 (lat 6)", y, lat); end
      @(posedge clk); #1;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_impulse();
      test_step_wrap();
      test_backpressure();
      test_saturation();
      test_reset_mid_mac();
      test_coef_busy();
      test_same_cycle_coef();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
